// File: rtl/placement_wirelength_eval.sv
// Wirelength cost evaluator: walks the EA/EB edge ROMs, reads both endpoint positions and accumulates the Manhattan and 1-hop costs.
// Latency: 5 cycles per edge, done at start+5*N_EDGE+2; start is ignored while busy or done, no queueing, no backpressure on memories.
// Optional max_len output enabled by defining PLACE_EVAL_MAXLEN_EN.
module placement_wirelength_eval #(
    parameter int N_EDGE = 19,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              edge_re,
    output logic [ADDR_W-1:0] edge_addr,
    input  logic [DATA_W-1:0] edge_a,
    input  logic [DATA_W-1:0] edge_b,
    output logic              pos_re,
    output logic [ADDR_W-1:0] pos_addr,
    input  logic [DATA_W-1:0] pos_x,
    input  logic [DATA_W-1:0] pos_y,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] sum_1hop,
    output logic [DATA_W-1:0] cycles,
    output logic              err_unplaced
`ifdef PLACE_EVAL_MAXLEN_EN
    ,
    output logic [DATA_W-1:0] max_len
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EDGE = 3'd1,
        POSA = 3'd2,
        POSB = 3'd3,
        DIFF = 3'd4,
        ACC  = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] ax_q, ay_q;
    logic [DATA_W-1:0] dx_q, dy_q;
    logic              unplaced_q;

    logic [DATA_W-1:0] adx, ady;
    logic [DATA_W-1:0] hdx, hdy;
    logic [DATA_W-1:0] len;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? ((v ^ ALL_ONES) + DATA_W'(1)) : v;
    endfunction

    // Absolute distances and their rounded-up halves (cells per hop = 2).
    always_comb begin
        adx = abs_val(dx_q);
        ady = abs_val(dy_q);
        hdx = (adx >> 1) + {{(DATA_W-1){1'b0}}, adx[0]};
        hdy = (ady >> 1) + {{(DATA_W-1){1'b0}}, ady[0]};
        len = adx + ady;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        edge_re   = 1'b0;
        edge_addr = '0;
        pos_re    = 1'b0;
        pos_addr  = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = EDGE;
            end
            EDGE: begin
                busy = 1'b1;
                if (idx == ADDR_W'(N_EDGE)) begin
                    state_nxt = DONE;
                end else begin
                    edge_re   = 1'b1;
                    edge_addr = idx;
                    state_nxt = POSA;
                end
            end
            POSA: begin
                busy      = 1'b1;
                pos_re    = 1'b1;
                pos_addr  = ADDR_W'(edge_a);
                state_nxt = POSB;
            end
            POSB: begin
                busy      = 1'b1;
                pos_re    = 1'b1;
                pos_addr  = ADDR_W'(b_q);
                state_nxt = DIFF;
            end
            DIFF: begin
                busy      = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                busy      = 1'b1;
                state_nxt = EDGE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            b_q          <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            unplaced_q   <= 1'b0;
            sum          <= '0;
            sum_1hop     <= '0;
            cycles       <= '0;
            err_unplaced <= 1'b0;
`ifdef PLACE_EVAL_MAXLEN_EN
            max_len      <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (busy) cycles <= cycles + DATA_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        sum          <= '0;
                        sum_1hop     <= '0;
                        cycles       <= '0;
                        err_unplaced <= 1'b0;
`ifdef PLACE_EVAL_MAXLEN_EN
                        max_len      <= '0;
`endif
                    end
                end
                POSA: b_q <= edge_b;
                POSB: begin
                    ax_q <= pos_x;
                    ay_q <= pos_y;
                end
                DIFF: begin
                    dx_q       <= ax_q - pos_x;
                    dy_q       <= ay_q - pos_y;
                    unplaced_q <= (ax_q == ALL_ONES) || (ay_q == ALL_ONES) ||
                                  (pos_x == ALL_ONES) || (pos_y == ALL_ONES);
                end
                ACC: begin
                    // A same-cell edge contributes -1; accumulators wrap freely.
                    if (unplaced_q) begin
                        err_unplaced <= 1'b1;
                    end else begin
                        sum      <= sum + len - DATA_W'(1);
                        sum_1hop <= sum_1hop + hdx + hdy - DATA_W'(1);
`ifdef PLACE_EVAL_MAXLEN_EN
                        if ($signed(len) > $signed(max_len)) max_len <= len;
`endif
                    end
                    idx <= idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_wirelength_eval.sv
// Scoreboard bench for placement_wirelength_eval: a 3-edge instance for the cost tests and a 0-edge instance for the empty case.
module tb_placement_wirelength_eval;

    localparam int W  = 32;
    localparam int NE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, start0;
    logic         busy, done, edge_re, pos_re;
    logic [W-1:0] edge_addr, pos_addr, edge_a, edge_b, pos_x, pos_y;
    logic [W-1:0] sum, sum_1hop, cycles;
    logic         err_unplaced;
    logic         busy0, done0, edge_re0, pos_re0, err0;
    logic [W-1:0] edge_addr0, pos_addr0, sum0, s1_0, cycles0;
`ifdef PLACE_EVAL_MAXLEN_EN
    logic [W-1:0] max_len, max_len0;
`endif

    placement_wirelength_eval #(.N_EDGE(NE), .DATA_W(W), .ADDR_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
        .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
        .sum(sum), .sum_1hop(sum_1hop), .cycles(cycles), .err_unplaced(err_unplaced)
`ifdef PLACE_EVAL_MAXLEN_EN
        , .max_len(max_len)
`endif
    );

    placement_wirelength_eval #(.N_EDGE(0), .DATA_W(W), .ADDR_W(W)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .edge_re(edge_re0), .edge_addr(edge_addr0), .edge_a('0), .edge_b('0),
        .pos_re(pos_re0), .pos_addr(pos_addr0), .pos_x('0), .pos_y('0),
        .sum(sum0), .sum_1hop(s1_0), .cycles(cycles0), .err_unplaced(err0)
`ifdef PLACE_EVAL_MAXLEN_EN
        , .max_len(max_len0)
`endif
    );

    // Edge ROMs and position RAMs with a registered read; garbage when not read.
    logic [W-1:0] ea [NE];
    logic [W-1:0] eb [NE];
    logic [W-1:0] px [16];
    logic [W-1:0] py [16];

    always @(posedge clk) begin
        if (edge_re && edge_addr < NE) begin
            edge_a <= ea[edge_addr[1:0]];
            edge_b <= eb[edge_addr[1:0]];
        end else begin
            edge_a <= 32'hDEAD_BEEF;
            edge_b <= 32'hDEAD_BEEF;
        end
        if (pos_re && pos_addr < 16) begin
            pos_x <= px[pos_addr[3:0]];
            pos_y <= py[pos_addr[3:0]];
        end else begin
            pos_x <= 32'h0BAD_F00D;
            pos_y <= 32'h0BAD_F00D;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic edge_re0_seen = 1'b0;
    always @(posedge clk) if (edge_re0) edge_re0_seen <= 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] s1;
        logic [W-1:0] cyc;
        logic         err;
        logic [W-1:0] mx;
        int           done_at;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;

    // Scoreboard: each done pops one expectation pushed when start was driven.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                got_e = sb.pop_front();
                chk("done_cycle", cyc, got_e.done_at);
                chk("busy_at_done", {31'd0, busy}, 0);
                chk("sum", sum, got_e.sum);
                chk("sum_1hop", sum_1hop, got_e.s1);
                chk("cycles", cycles, got_e.cyc);
                chk("err_unplaced", {31'd0, err_unplaced}, {31'd0, got_e.err});
`ifdef PLACE_EVAL_MAXLEN_EN
                chk("max_len", max_len, got_e.mx);
`endif
            end
        end
    end

    function automatic exp_t mk(input int s, input int s1, input bit e, input int mx);
        exp_t r;
        r.sum = s; r.s1 = s1; r.cyc = 5 * NE + 1; r.err = e; r.mx = mx; r.done_at = 0;
        return r;
    endfunction

    // Reference cost computed straight from the definition (ceil halves).
    function automatic exp_t model();
        exp_t r;
        logic signed [W-1:0] ax, ay, bx, by, dx, dy, adx, ady;
        r = mk(0, 0, 1'b0, 0);
        for (int e = 0; e < NE; e++) begin
            ax = px[ea[e][3:0]]; ay = py[ea[e][3:0]];
            bx = px[eb[e][3:0]]; by = py[eb[e][3:0]];
            if (ax == -1 || ay == -1 || bx == -1 || by == -1) begin
                r.err = 1'b1;
            end else begin
                dx = ax - bx; dy = ay - by;
                adx = (dx < 0) ? -dx : dx;
                ady = (dy < 0) ? -dy : dy;
                r.sum = r.sum + adx + ady - 1;
                r.s1  = r.s1 + (adx + 1) / 2 + (ady + 1) / 2 - 1;
                if (adx + ady > $signed(r.mx)) r.mx = adx + ady;
            end
        end
        return r;
    endfunction

    task automatic load_graph1();
        ea[0] = 0; eb[0] = 1; ea[1] = 1; eb[1] = 2; ea[2] = 2; eb[2] = 3;
        px[0] = 0; py[0] = 0; px[1] = 0; py[1] = 1;
        px[2] = 2; py[2] = 3; px[3] = 3; py[3] = 3;
    endtask

    // Caller is at a negedge with the DUT idle.
    task automatic start_run(input exp_t e);
        start = 1'b1;
        e.done_at = cyc + 5 * NE + 2;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_sum_1hop"}, sum_1hop, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_flags"}, {26'd0, err_unplaced, busy, done, edge_re, pos_re, 1'b0}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, got;
        exp_t e;
        reset = 1'b1; start = 1'b0; start0 = 1'b0;
        for (int k = 0; k < 16; k++) begin px[k] = 0; py[k] = 0; end
        load_graph1();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Placed graph.
        start_run(mk(3, 1, 1'b0, 4));
        wait_drain(40);

        // Unplaced node n2.
        px[2] = 32'hFFFF_FFFF;
        start_run(mk(0, 0, 1'b1, 1));
        wait_drain(40);

        // Negative differences plus two same-cell edges.
        ea[0] = 3; eb[0] = 0; ea[1] = 0; eb[1] = 0; ea[2] = 3; eb[2] = 3;
        px[3] = 0; py[3] = 0; px[0] = 3; py[0] = 2;
        start_run(mk(2, 0, 1'b0, 5));
        wait_drain(40);

        // Stray starts at cycles 3 and 10 of a run.
        load_graph1();
        start_run(mk(3, 1, 1'b0, 4));
        repeat (2) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_drain(40);
        repeat (20) @(negedge clk);
        chk("no_extra_run", sb.size(), 0);

        // Start held high: three back-to-back runs, 18 cycles apart.
        t0 = cyc;
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            e = mk(3, 1, 1'b0, 4);
            e.done_at = t0 + 17 + 18 * r;
            sb.push_back(e);
        end
        repeat (53) @(negedge clk);
        start = 1'b0;
        wait_drain(40);

        // Reset during POSB of edge 1 (cycle start+8).
        start_run(mk(3, 1, 1'b0, 4));
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        start_run(mk(3, 1, 1'b0, 4));
        wait_drain(40);

        // Random graphs against the reference model.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NE; k++) begin
                ea[k] = $urandom_range(0, 15);
                eb[k] = $urandom_range(0, 15);
            end
            for (int k = 0; k < 16; k++) begin
                px[k] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 15);
                py[k] = $urandom_range(0, 15);
            end
            start_run(model());
            wait_drain(40);
        end

        // Zero-edge instance.
        t0 = cyc;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        got = -1;
        for (int k = 0; k < 10 && got < 0; k++) begin
            if (done0) got = cyc;
            else @(negedge clk);
        end
        chk("n0_done_cycle", got, t0 + 2);
        chk("n0_sum", sum0, 0);
        chk("n0_sum_1hop", s1_0, 0);
        chk("n0_cycles", cycles0, 1);
        chk("n0_edge_re_seen", {31'd0, edge_re0_seen}, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/placement_wirelength_eval.md
Name: placement_wirelength_eval

Overview:
- Standalone cost-evaluation stage downstream of the random/walk placer.
- After the placer has written the X/Y position RAMs, this block walks the edge list (EA/EB ROMs) and reads both endpoint positions for each edge.
- It accumulates the Manhattan wirelength cost and the 1-hop (two cells per hop) cost.
- It reports both totals, a cycle count and an unplaced-node error through a start/done handshake.

Parameters:
- N_EDGE, 19, number of edges in the EA/EB ROMs (addresses 0..N_EDGE-1).
- DATA_W, 32, width of node IDs, coordinates and accumulators (signed).
- ADDR_W, 32, width of the edge and position memory address ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request evaluation; sampled only in IDLE.
- busy  out  1  high from the first cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when results are final.
- edge_re  out  1  read enable to the EA and EB ROMs (shared).
- edge_addr  out  ADDR_W  edge index.
- edge_a  in  DATA_W  EA ROM data; valid the cycle after edge_re.
- edge_b  in  DATA_W  EB ROM data; valid the cycle after edge_re.
- pos_re  out  1  read enable to the pos_X and pos_Y RAMs (shared).
- pos_addr  out  ADDR_W  node ID to read.
- pos_x  in  DATA_W  pos_X data; valid the cycle after pos_re.
- pos_y  in  DATA_W  pos_Y data; valid the cycle after pos_re.
- sum  out  DATA_W  Manhattan cost, sum of (|dx|+|dy|-1).
- sum_1hop  out  DATA_W  sum of (ceil(|dx|/2)+ceil(|dy|/2)-1).
- cycles  out  DATA_W  number of clk cycles spent busy in the last run.
- err_unplaced  out  1  sticky; some edge endpoint had a coordinate of -1.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; edge index i=0; internal registers 0.
  - Reset mid-run aborts immediately with no done pulse.
- Memory model: registered 1-cycle read. Data is sampled exactly one cycle after its re was high. Reads are never overlapped.
- State machine (one state per cycle):
  - IDLE: if start=1, clear sum, sum_1hop, cycles, err_unplaced and i, then go to EDGE. Otherwise stay in IDLE.
  - EDGE:
    - If i==N_EDGE, go to DONE.
    - Otherwise drive edge_re=1 and edge_addr=i, then go to POSA.
  - POSA: latch a=edge_a and b=edge_b; drive pos_re=1, pos_addr=edge_a; go to POSB.
  - POSB: latch ax=pos_x, ay=pos_y; drive pos_re=1, pos_addr=b; go to DIFF.
  - DIFF: compute dx=ax-pos_x and dy=ay-pos_y (signed DATA_W, two's complement); latch an unplaced flag if any of ax, ay, pos_x, pos_y equals -1; go to ACC.
  - ACC:
    - Take absolute values: |v| = (v XOR all-ones)+1 when v<0.
    - If the edge is placed: sum += |dx|+|dy|-1 and sum_1hop += (|dx|>>1)+|dx|[0] + (|dy|>>1)+|dy|[0] - 1.
    - If the edge is unplaced: set err_unplaced and leave both accumulators unchanged.
    - i++; go to EDGE.
  - DONE: done=1 for this cycle; busy=0; go to IDLE.
- Timing:
  - 5 cycles per edge.
  - Start sampled at cycle t gives done at t+5*N_EDGE+2.
  - cycles holds 5*N_EDGE+1, the number of cycles busy was high.
- busy is high in the EDGE, POSA, POSB, DIFF and ACC states.
- start while busy or in DONE is ignored; there is no queueing.
- Results (sum, sum_1hop, cycles, err_unplaced) hold their values until the next accepted start.
- edge_re and pos_re are high only in the states listed above and 0 everywhere else.
- N_EDGE=0: done is asserted at t+2 with all results 0.
- Accumulators wrap modulo 2^DATA_W with no saturation. An edge with both endpoints on the same cell contributes -1, matching the placer cost definition.

Optional Feature:
- Macro: PLACE_EVAL_MAXLEN_EN.
- When defined:
  - Adds output max_len (out, DATA_W), holding the maximum of |dx|+|dy| over placed edges.
  - Updated in ACC; cleared on reset and on start.
- When undefined: the port and its logic are absent. All other behaviour and timing are identical.

Test Plan:
- Placed run, N_EDGE=3:
  - Edges (0,1), (1,2), (2,3).
  - Positions: n0=(0,0), n1=(0,1), n2=(2,3), n3=(3,3).
  - Required: sum=3, sum_1hop=1, err_unplaced=0, done exactly 17 cycles after start, cycles=16, max_len=4 when the macro is enabled.
- Unplaced node: same graph with n2 x=-1.
  - Required: err_unplaced=1, sum=0 (edge0 only), sum_1hop=0, same done timing.
- Negative differences: single edge (3,0) with n3=(0,0), n0=(3,2).
  - Required: sum=4, sum_1hop=2.
- Handshake:
  - Pulse start again at cycles 3 and 10 of a run: both ignored, exactly one done.
  - Start held high continuously: back-to-back runs, with identical results in each run.
- Reset mid-run: assert reset during POSB of edge 1.
  - Required next cycle: all outputs 0, no done.
  - A new start gives correct full results.
- N_EDGE=0 build: done at start+2, sum=0, sum_1hop=0, cycles=1, and edge_re never asserted.
